// File: rtl/shiftreg_rx.sv
// shiftreg_rx: serial-to-parallel receiver. Frames N-bit words from a serial
// bit stream (MSB-first or LSB-first, chosen per word on its first bit) and
// hands each completed word to a valid/ready output register with sticky
// overrun detection.
module shiftreg_rx #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bit_in,
    input  logic         bit_valid,
    input  logic         sync,
    input  logic         dir,
    input  logic         word_ready,
    input  logic         clr_ovr,
    output logic [N-1:0] word_out,
    output logic         word_valid,
    output logic         overrun,
    output logic         busy
);

    localparam int CW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state;
    logic [N-1:0]  sh;
    logic [CW-1:0] cnt;
    logic          dir_q;

    logic          start;
    logic          last;
    logic          dir_use;
    logic [N-1:0]  sh_base;
    logic [N-1:0]  sh_next;

    // Next-shift datapath: a word starts fresh on the first bit (or on a sync
    // that carries a bit), taking its direction from dir at that moment.
    always_comb begin
        start   = bit_valid && (sync || (state == IDLE));
        dir_use = start ? dir : dir_q;
        sh_base = start ? '0 : sh;
        sh_next = dir_use ? {bit_in, sh_base[N-1:1]} : {sh_base[N-2:0], bit_in};
        last    = bit_valid && !start && (cnt == CW'(N - 1));
    end

    // Receive FSM: frames bits into words; sync discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
            dir_q <= 1'b0;
        end else if (sync && !bit_valid) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
        end else if (bit_valid) begin
            sh <= sh_next;
            if (start) begin
                dir_q <= dir;
                cnt   <= CW'(1);
                state <= SHIFT;
            end else if (last) begin
                cnt   <= '0;
                state <= IDLE;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Output register: load a completed word when the slot is free or being
    // drained this edge, otherwise drop it and flag overrun (set beats clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (last) begin
                if (!word_valid || word_ready) begin
                    word_out   <= sh_next;
                    word_valid <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            if (last && word_valid && !word_ready) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: doc/shiftreg_rx.md
# shiftreg_rx

Serial-to-parallel receiver that reassembles N-bit words from the serial bit stream emitted by the team's loadable left/right shift register. It frames bits into words with a bit counter, supports both shift directions (MSB-first and LSB-first), and presents each completed word through a valid/ready output register with sticky overrun detection. It sits at the receiving end of the serial link, between the line and the parallel consumer.

## Interface
- N, default 4, word width in bits; N >= 2.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is sampled on this edge.
- sync  input  1  frame start: discards any partial word.
- dir  input  1  0 = MSB-first (shift left: {sh[N-2:0], bit_in}); 1 = LSB-first (shift right: {bit_in, sh[N-1:1]}).
- word_ready  input  1  consumer accepts word_out.
- clr_ovr  input  1  clears overrun.
- word_out  output  N  last completed word.
- word_valid  output  1  word_out holds an unconsumed word.
- overrun  output  1  sticky: a completed word was dropped.
- busy  output  1  partial word in progress (count != 0).

## Operation
- Internal state: shift register sh[N-1:0], bit counter cnt (0..N-1, width clog2(N)), latched direction dir_q, output register word_out, word_valid, overrun.
- Receive FSM: IDLE (cnt == 0) and SHIFT (0 < cnt < N).
- IDLE, bit_valid = 1: latch dir_q <= dir, shift bit_in in using the new dir, cnt <= 1, go to SHIFT.
- SHIFT, bit_valid = 1: shift using dir_q (dir is ignored mid-word), cnt <= cnt + 1.
- On the N-th bit (cnt == N-1 with bit_valid): the completed word (sh with this bit shifted in) becomes the candidate word; cnt <= 0; go to IDLE.
- bit_valid = 0: sh, cnt and dir_q hold.
- sync = 1 takes priority over the FSM:
  - with bit_valid = 0: cnt <= 0 and sh <= 0.
  - with bit_valid = 1: the partial word is discarded and bit_in is treated as the first bit of a new word (IDLE rule, dir freshly latched).
- Output register:
  - Accept: word_valid && word_ready at an edge consumes the word; word_valid <= 0 unless a candidate word completes on the same edge.
  - Candidate completes, output empty or being accepted on that edge: word_out <= candidate, word_valid <= 1.
  - Candidate completes, word_valid = 1 and word_ready = 0: candidate is dropped, word_out is unchanged, overrun <= 1.
- overrun stays set until clr_ovr = 1. If clr_ovr and a new overrun occur on the same edge, overrun stays 1 (set wins).
- busy = (cnt != 0), combinational from the register.

## Timing
- Reset values: sh = 0, cnt = 0, dir_q = 0, word_out = 0, word_valid = 0, overrun = 0, busy = 0. Reset is asynchronous and may abort a word mid-stream; no partial state survives.
- Latency: word_out and word_valid update on the same edge that samples the N-th bit and are visible in the following cycle.
- Throughput: one bit per cycle, one word per N cycles. A consumer that holds word_ready high never sees an overrun.
- word_out is stable whenever word_valid = 1 and no accept has occurred.
- Back-to-back case: with word_valid = 1 and word_ready = 1 on the completion edge, the new word loads, word_valid stays 1, and no overrun is flagged.

## Test plan
- Reset, then N=4, dir = 0, bits 1,0,1,1 on consecutive cycles with word_ready = 1 -> word_out = 4'b1011, word_valid high for exactly 1 cycle after the 4th bit, overrun = 0.
- dir = 1, same bits 1,0,1,1 -> word_out = 4'b1101. Repeat with dir toggled after the first bit -> still 4'b1101, because dir_q is latched on the first bit.
- word_ready = 0; send 4'hA (MSB-first) then 4'h5 -> word_out stays 4'hA, overrun = 1. Raise word_ready -> word_valid drops next cycle. Pulse clr_ovr -> overrun = 0.
- Send 2 bits, pulse sync with bit_valid = 0, then send 1,1,0,0 MSB-first -> word_out = 4'b1100, busy = 0 afterwards.
- Send 3 bits, then sync with bit_valid = 1 and bit_in = 1, followed by 0,0,0 -> word_out = 4'b1000.
- Assert rst asynchronously mid-word (cnt = 2) with word_valid = 1 -> all outputs are 0 immediately. The next 4 bits form a clean word.
